alu_pipe: RTL



---
 rtl/alu_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with a serial shifter and status flags
// Define ALU_SAT_EN to make ADD/SUB saturate on overflow; left undefined, they wrap.
module alu_pipe #(
  parameter int NB_OP   = 6,
  parameter int NB_DATA = 8,
  parameter int NB_CNT  = $clog2(NB_DATA + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_OP-1:0]   i_operation,
  input  logic [NB_DATA-1:0] i_Adata,
  input  logic [NB_DATA-1:0] i_Bdata,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_ovf,
  output logic               o_err
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [NB_DATA-1:0]  data_q, data_d;
  logic [NB_CNT-1:0]   cnt_q, cnt_d;
  logic                sra_q, sra_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;

  logic [NB_DATA:0]    sum_ext;
  logic [NB_DATA-1:0]  alu_res;
  logic                alu_ovf;
  logic                alu_err;
  logic                is_shift;
  logic [NB_CNT-1:0]   shamt;
  logic [NB_DATA-1:0]  shifted;
  logic                accept;

  assign o_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && i_ready);
  assign o_valid  = (state_q == S_DONE);
  assign accept   = i_valid && o_ready;
  assign o_result = data_q;
  assign o_zero   = zero_q;
  assign o_ovf    = ovf_q;
  assign o_err    = err_q;

  // One shifter step: the fill bit is the sign only for SRA.
  assign shifted = {sra_q & data_q[NB_DATA-1], data_q[NB_DATA-1:1]};

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_err  = 1'b0;
    is_shift = 1'b0;
    sum_ext  = '0;
    if (i_Bdata >= NB_DATA'(NB_DATA)) shamt = NB_CNT'(NB_DATA);
    else                              shamt = i_Bdata[NB_CNT-1:0];
    case (i_operation)
      OP_ADD, OP_SUB: begin
        if (i_operation == OP_SUB)
          sum_ext = {i_Adata[NB_DATA-1], i_Adata} - {i_Bdata[NB_DATA-1], i_Bdata};
        else
          sum_ext = {i_Adata[NB_DATA-1], i_Adata} + {i_Bdata[NB_DATA-1], i_Bdata};
        alu_ovf = sum_ext[NB_DATA] ^ sum_ext[NB_DATA-1];
        alu_res = sum_ext[NB_DATA-1:0];
`ifdef ALU_SAT_EN
        // The extra top bit is the true sign, so it picks which rail to clamp to.
        if (alu_ovf)
          alu_res = sum_ext[NB_DATA] ? {1'b1, {(NB_DATA-1){1'b0}}}
                                     : {1'b0, {(NB_DATA-1){1'b1}}};
`endif
      end
      OP_AND: alu_res = i_Adata & i_Bdata;
      OP_OR:  alu_res = i_Adata | i_Bdata;
      OP_XOR: alu_res = i_Adata ^ i_Bdata;
      OP_NOR: alu_res = ~(i_Adata | i_Bdata);
      OP_SRL, OP_SRA: begin
        is_shift = 1'b1;
        alu_res  = i_Adata;
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    sra_d   = sra_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (is_shift && (shamt != '0)) begin
            data_d  = i_Adata;
            cnt_d   = shamt;
            sra_d   = (i_operation == OP_SRA);
            state_d = S_SHIFT;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            ovf_d   = alu_ovf;
            err_d   = alu_err;
            state_d = S_DONE;
          end
        end else if (state_q == S_DONE && i_ready) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        data_d = shifted;
        cnt_d  = cnt_q - NB_CNT'(1);
        if (cnt_q == NB_CNT'(1)) begin
          zero_d  = (shifted == '0);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      sra_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      sra_q   <= sra_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

endmodule
